// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by the fetch top and its next-PC helper.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_STATE_IDLE    = 3'd0,
    FETCH_STATE_REQUEST = 3'd1,
    FETCH_STATE_WAIT    = 3'd2,
    FETCH_STATE_HOLD    = 3'd3,
    FETCH_STATE_DISCARD = 3'd4,
    FETCH_STATE_FAULT   = 3'd5
  } fetch_state_e;

  localparam logic [1:0] FETCH_CAUSE_NONE       = 2'b00;
  localparam logic [1:0] FETCH_CAUSE_ACCESS     = 2'b01;
  localparam logic [1:0] FETCH_CAUSE_MISALIGNED = 2'b10;

  localparam int unsigned INSTRUCTION_BYTES = 4;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Next-PC select: redirect, sequential advance or hold.
// Also flags a redirect target that is not word aligned.
module instruction_fetch_pc_next
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_advance,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);

  logic w_bad;

  assign w_bad = is_misaligned(i_redirect_pc);

  // Redirect beats advance; a bad target leaves the PC alone
  always_comb begin
    o_misaligned = i_redirect_valid && w_bad;
    o_next_pc    = i_pc;
    unique case (1'b1)
      (i_redirect_valid && !w_bad):
        o_next_pc = i_redirect_pc;
      (!i_redirect_valid && i_advance):
        o_next_pc = i_pc + 32'(INSTRUCTION_BYTES);
      default:
        o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, one fetch in flight at a time,
// holds the word for decode, handles redirects and faults.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_error,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        fetch_error,
  output logic [1:0]  fetch_error_cause,
  output logic [31:0] fetch_error_pc
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [1:0]  r_cause;
  logic [31:0] r_err_pc;

  logic [31:0] w_next_pc;
  logic        w_misaligned;
  logic        w_redir_ok;
  logic        w_advance;
  logic        w_resp_take;
  logic        w_resp_fault;

  assign w_redir_ok = redirect_valid && !w_misaligned;
  assign w_advance  = (r_state == FETCH_STATE_HOLD)
                   && instruction_ready;

  assign w_resp_take  = (r_state == FETCH_STATE_WAIT)
                     && mem_resp_valid && !redirect_valid
                     && !mem_resp_error;
  assign w_resp_fault = (r_state == FETCH_STATE_WAIT)
                     && mem_resp_valid && !redirect_valid
                     && mem_resp_error;

  instruction_fetch_pc_next u_pc_next (
    .i_pc             (r_pc),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_advance        (w_advance),
    .o_next_pc        (w_next_pc),
    .o_misaligned     (w_misaligned)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= FETCH_STATE_IDLE;
    else          r_state <= w_state_next;
  end

  // Next state; redirects override every other event
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      FETCH_STATE_IDLE:
        w_state_next = FETCH_STATE_REQUEST;
      FETCH_STATE_REQUEST:
        if (mem_req_ready) w_state_next = FETCH_STATE_WAIT;
      FETCH_STATE_WAIT:
        if (mem_resp_valid)
          w_state_next = mem_resp_error ? FETCH_STATE_FAULT
                                        : FETCH_STATE_HOLD;
      FETCH_STATE_HOLD:
        if (instruction_ready) w_state_next = FETCH_STATE_REQUEST;
      FETCH_STATE_DISCARD:
        if (mem_resp_valid) w_state_next = FETCH_STATE_REQUEST;
      FETCH_STATE_FAULT:
        w_state_next = FETCH_STATE_FAULT;
      default:
        w_state_next = FETCH_STATE_IDLE;
    endcase
    if (w_misaligned) begin
      w_state_next = FETCH_STATE_FAULT;
    end else if (w_redir_ok) begin
      unique case (r_state)
        FETCH_STATE_REQUEST:
          w_state_next = mem_req_ready ? FETCH_STATE_DISCARD
                                       : FETCH_STATE_REQUEST;
        FETCH_STATE_WAIT, FETCH_STATE_DISCARD:
          // a response arriving now is the stale one, so the
          // new fetch can start straight away
          w_state_next = mem_resp_valid ? FETCH_STATE_REQUEST
                                        : FETCH_STATE_DISCARD;
        default:
          w_state_next = FETCH_STATE_REQUEST;
      endcase
    end
  end

  // PC, held instruction and fault bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_VECTOR;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_cause    <= FETCH_CAUSE_NONE;
      r_err_pc   <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_resp_take) begin
        r_instr    <= mem_resp_data;
        r_instr_pc <= r_pc;
      end
      if (w_misaligned) begin
        r_cause  <= FETCH_CAUSE_MISALIGNED;
        r_err_pc <= redirect_pc;
      end else if (w_redir_ok
                   && r_state == FETCH_STATE_FAULT) begin
        r_cause  <= FETCH_CAUSE_NONE;
        r_err_pc <= '0;
      end else if (w_resp_fault) begin
        r_cause  <= FETCH_CAUSE_ACCESS;
        r_err_pc <= r_pc;
      end
    end
  end

  // Moore outputs decoded from state and registers
  always_comb begin
    mem_req_valid     = (r_state == FETCH_STATE_REQUEST);
    mem_req_addr      = r_pc;
    instruction_valid = (r_state == FETCH_STATE_HOLD);
    instruction       = r_instr;
    instruction_pc    = r_instr_pc;
    fetch_error       = (r_state == FETCH_STATE_FAULT);
    fetch_error_cause = r_cause;
    fetch_error_pc    = r_err_pc;
  end

endmodule
